// File: rtl/spart_pkg.sv
// Shared serial-port definitions: receiver FSM encoding and parity modes.
// Also used by the transmit side.
package spart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP
   } rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so an idle line never looks like a start bit.
module rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic ff1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff1 <= 1'b1;
         q   <= 1'b1;
      end else begin
         ff1 <= d;
         q   <= ff1;
      end
   end

endmodule

// File: rtl/rx_framer.sv
// Oversampling UART receive framer with majority vote per bit.
// Holds one completed frame for the consumer and flags overrun.
module rx_framer
   import spart_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int OVS       = 16,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              brg_en,
   input  logic              rx_in,
   input  logic              rx_rd,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err,
   output logic              parity_err,
   output logic              overrun,
   output logic              busy
);

   localparam int TW = $clog2(OVS);
   localparam int BW = $clog2(DATA_W + 1);

   rx_state_t         state, state_n;
   logic [TW-1:0]     tcnt, tcnt_n, tcnt_inc;
   logic [BW-1:0]     bcnt, bcnt_n;
   logic              scnt, scnt_n;
   logic [DATA_W-1:0] sh, sh_n;
   logic              s1, s1_n;
   logic              s2, s2_n;
   logic              perr, perr_n;
   logic              ferr, ferr_n;
   logic              rxs;
   logic              wrap, at_v, vote, done;

   rx_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_in),
      .q     (rxs)
   );

   assign wrap     = (tcnt == TW'(OVS - 1));
   assign at_v     = (tcnt == TW'(OVS / 2 + 1));
   assign tcnt_inc = wrap ? '0 : tcnt + 1'b1;
   assign vote     = maj3(s1, s2, rxs);
   assign busy     = (state != ST_IDLE);

   always_comb begin
      state_n = state;
      tcnt_n  = tcnt;
      bcnt_n  = bcnt;
      scnt_n  = scnt;
      sh_n    = sh;
      s1_n    = s1;
      s2_n    = s2;
      perr_n  = perr;
      ferr_n  = ferr;
      done    = 1'b0;
      if (brg_en) begin
         if (tcnt == TW'(OVS / 2 - 1)) s1_n = rxs;
         if (tcnt == TW'(OVS / 2))     s2_n = rxs;
         unique case (state)
            ST_IDLE: begin
               if (!rxs) begin
                  state_n = ST_START;
                  tcnt_n  = '0;
                  bcnt_n  = '0;
                  scnt_n  = 1'b0;
                  perr_n  = 1'b0;
                  ferr_n  = 1'b0;
               end
            end
            ST_START: begin
               tcnt_n = tcnt_inc;
               if (at_v && vote) begin
                  state_n = ST_IDLE;
                  tcnt_n  = '0;
               end else if (wrap) begin
                  state_n = ST_DATA;
               end
            end
            ST_DATA: begin
               tcnt_n = tcnt_inc;
               if (at_v) begin
                  sh_n   = {vote, sh[DATA_W-1:1]};
                  bcnt_n = bcnt + 1'b1;
               end
               if (wrap && bcnt == BW'(DATA_W)) begin
                  bcnt_n  = '0;
                  state_n = (PARITY == PAR_NONE) ? ST_STOP : ST_PAR;
               end
            end
            ST_PAR: begin
               tcnt_n = tcnt_inc;
               if (at_v)
                  perr_n = vote ^ (^sh) ^ (PARITY == PAR_ODD);
               if (wrap) state_n = ST_STOP;
            end
            ST_STOP: begin
               tcnt_n = tcnt_inc;
               if (at_v) begin
                  ferr_n = ferr | ~vote;
                  // last stop bit ends the frame mid-bit to resync early
                  if (scnt == 1'(STOP_BITS - 1)) begin
                     done    = 1'b1;
                     state_n = ST_IDLE;
                     tcnt_n  = '0;
                  end
               end
               if (wrap) scnt_n = 1'b1;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         tcnt  <= '0;
         bcnt  <= '0;
         scnt  <= 1'b0;
         sh    <= '0;
         s1    <= 1'b1;
         s2    <= 1'b1;
         perr  <= 1'b0;
         ferr  <= 1'b0;
      end else begin
         state <= state_n;
         tcnt  <= tcnt_n;
         bcnt  <= bcnt_n;
         scnt  <= scnt_n;
         sh    <= sh_n;
         s1    <= s1_n;
         s2    <= s2_n;
         perr  <= perr_n;
         ferr  <= ferr_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else if (done) begin
         rx_data    <= sh;
         frame_err  <= ferr_n;
         parity_err <= perr;
         rx_valid   <= 1'b1;
         if (rx_valid && !rx_rd)
            overrun <= 1'b1;
         else if (rx_valid && rx_rd)
            overrun <= 1'b0;
      end else if (rx_valid && rx_rd) begin
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rx_framer.sv
// Self-checking bench: 8N1 and 8E1 receivers on one shared serial line.
// Expected fields and timing come from the frame contents and bit-period arithmetic.
module tb_rx_framer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic brg_en = 1'b0;
   logic rx_in = 1'b1;
   logic rd0 = 1'b0;
   logic rd1 = 1'b0;
   logic [7:0] d0_data, d1_data;
   logic d0_valid, d0_ferr, d0_perr, d0_ovr, d0_busy;
   logic d1_valid, d1_ferr, d1_perr, d1_ovr, d1_busy;

   int nchk = 0;
   int npass = 0;
   int cyc = 0;
   int c0 = 0;
   int bdiv = 0;

   localparam int BITCLK = 64;

   rx_framer #(.DATA_W(8), .OVS(16), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .brg_en(brg_en), .rx_in(rx_in),
      .rx_rd(rd0), .rx_data(d0_data), .rx_valid(d0_valid),
      .frame_err(d0_ferr), .parity_err(d0_perr), .overrun(d0_ovr),
      .busy(d0_busy)
   );

   rx_framer #(.DATA_W(8), .OVS(16), .PARITY(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .brg_en(brg_en), .rx_in(rx_in),
      .rx_rd(rd1), .rx_data(d1_data), .rx_valid(d1_valid),
      .frame_err(d1_ferr), .parity_err(d1_perr), .overrun(d1_ovr),
      .busy(d1_busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      bdiv = (bdiv + 1) % 4;
      brg_en = (bdiv == 0);
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rx_in = 1'b1;
      rd0 = 1'b0;
      rd1 = 1'b0;
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic align();
      do @(posedge clk); while (brg_en !== 1'b1);
      #1 c0 = cyc;
   endtask

   task automatic hold(input logic b);
      rx_in = b;
      repeat (BITCLK) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] d, input bit has_p,
                            input bit pbit, input bit stopv);
      hold(1'b0);
      for (int i = 0; i < 8; i++) hold(d[i]);
      if (has_p) hold(pbit);
      hold(stopv);
      hold(1'b1);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit has_p,
                             input bit pbit, input bit stopv);
      align();
      send_bits(d, has_p, pbit, stopv);
   endtask

   task automatic read0();
      @(posedge clk); #1 rd0 = 1'b1;
      @(posedge clk); #1 rd0 = 1'b0;
   endtask

   task automatic read1();
      @(posedge clk); #1 rd1 = 1'b1;
      @(posedge clk); #1 rd1 = 1'b0;
   endtask

   task automatic test_reset();
      logic [5:0] got;
      do_reset();
      got = {d0_valid, d0_ferr, d0_perr, d0_ovr, d0_busy, |d0_data};
      nchk++;
      if (got !== 6'b0) $display("FAIL reset_dut0 got=%b exp=000000", got);
      else npass++;
      got = {d1_valid, d1_ferr, d1_perr, d1_ovr, d1_busy, |d1_data};
      nchk++;
      if (got !== 6'b0) $display("FAIL reset_dut1 got=%b exp=000000", got);
      else npass++;
      read0();
      repeat (3) @(posedge clk);
      #1;
      nchk++;
      if ({d0_valid, d0_ovr} !== 2'b00)
         $display("FAIL rd_idle got=%b exp=00", {d0_valid, d0_ovr});
      else npass++;
   endtask

   task automatic test_basic();
      int tv = -1;
      do_reset();
      align();
      fork
         send_bits(8'hA5, 1'b0, 1'b0, 1'b1);
         begin
            for (int i = 0; i < 1000 && tv < 0; i++) begin
               @(posedge clk); #1;
               if (d0_valid) tv = cyc;
            end
         end
      join
      nchk++;
      if (tv !== c0 + 620)
         $display("FAIL a5_latency got=%0d exp=%0d", tv - c0, 620);
      else npass++;
      nchk++;
      if ({d0_valid, d0_data, d0_ferr, d0_perr, d0_ovr} !== {1'b1, 8'hA5, 3'b000})
         $display("FAIL a5_fields got=%b/%h/%b%b%b exp=1/a5/000",
                  d0_valid, d0_data, d0_ferr, d0_perr, d0_ovr);
      else npass++;
      read0();
      nchk++;
      if (d0_valid !== 1'b0) $display("FAIL a5_read got=%b exp=0", d0_valid);
      else npass++;
   endtask

   task automatic test_false_start();
      bit saw = 0;
      do_reset();
      align();
      rx_in = 1'b0;
      repeat (16) @(posedge clk);
      #1 rx_in = 1'b1;
      if (d0_busy) saw = 1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (d0_busy) saw = 1;
      end
      nchk++;
      if (saw !== 1'b1) $display("FAIL fs_busy_pulse got=%b exp=1", saw);
      else npass++;
      nchk++;
      if ({d0_busy, d0_valid} !== 2'b00)
         $display("FAIL fs_idle got=%b exp=00", {d0_busy, d0_valid});
      else npass++;
   endtask

   task automatic test_parity();
      do_reset();
      send_frame(8'h03, 1'b1, 1'b1, 1'b1);
      nchk++;
      if ({d1_valid, d1_data, d1_perr, d1_ferr} !== {1'b1, 8'h03, 2'b10})
         $display("FAIL par_bad got=%b/%h/%b%b exp=1/03/10",
                  d1_valid, d1_data, d1_perr, d1_ferr);
      else npass++;
      read1();
      send_frame(8'h03, 1'b1, 1'b0, 1'b1);
      nchk++;
      if ({d1_valid, d1_data, d1_perr, d1_ferr, d1_ovr} !== {1'b1, 8'h03, 3'b000})
         $display("FAIL par_good got=%b/%h/%b%b%b exp=1/03/000",
                  d1_valid, d1_data, d1_perr, d1_ferr, d1_ovr);
      else npass++;
      read1();
   endtask

   task automatic test_frame_err();
      do_reset();
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      nchk++;
      if ({d0_valid, d0_data, d0_ferr, d0_perr} !== {1'b1, 8'h5A, 2'b10})
         $display("FAIL ferr got=%b/%h/%b%b exp=1/5a/10",
                  d0_valid, d0_data, d0_ferr, d0_perr);
      else npass++;
      read0();
      nchk++;
      if ({d0_valid, d0_busy} !== 2'b00)
         $display("FAIL ferr_after got=%b exp=00", {d0_valid, d0_busy});
      else npass++;
   endtask

   task automatic test_overrun();
      do_reset();
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      nchk++;
      if ({d0_valid, d0_data, d0_ovr} !== {1'b1, 8'h22, 1'b1})
         $display("FAIL ovr got=%b/%h/%b exp=1/22/1", d0_valid, d0_data, d0_ovr);
      else npass++;
      read0();
      nchk++;
      if ({d0_valid, d0_ovr} !== 2'b00)
         $display("FAIL ovr_clear got=%b exp=00", {d0_valid, d0_ovr});
      else npass++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      align();
      fork
         send_bits(8'h96, 1'b0, 1'b0, 1'b1);
         begin
            while (cyc < c0 + 619) begin
               @(posedge clk); #1;
            end
            rd0 = 1'b1;
            @(posedge clk); #1 rd0 = 1'b0;
         end
      join
      nchk++;
      if ({d0_valid, d0_data, d0_ovr} !== {1'b1, 8'h96, 1'b0})
         $display("FAIL b2b got=%b/%h/%b exp=1/96/0", d0_valid, d0_data, d0_ovr);
      else npass++;
      read0();
   endtask

   task automatic test_reset_mid();
      bit moved = 0;
      do_reset();
      align();
      hold(1'b0);
      hold(1'b1);
      hold(1'b1);
      hold(1'b0);
      hold(1'b1);
      rst_n = 1'b0;
      rx_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (d0_valid || d0_busy || d0_ovr || d0_ferr) moved = 1;
      end
      nchk++;
      if (moved !== 1'b0) $display("FAIL rst_mid_quiet got=%b exp=0", moved);
      else npass++;
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
      nchk++;
      if ({d0_valid, d0_data, d0_ferr, d0_perr, d0_ovr} !== {1'b1, 8'hC3, 3'b000})
         $display("FAIL rst_mid_c3 got=%b/%h/%b%b%b exp=1/c3/000",
                  d0_valid, d0_data, d0_ferr, d0_perr, d0_ovr);
      else npass++;
      read0();
   endtask

   task automatic test_random();
      logic [7:0] d;
      bit sv, pb, ep;
      do_reset();
      for (int n = 0; n < 8; n++) begin
         d = 8'($urandom);
         sv = ($urandom_range(0, 3) != 0);
         send_frame(d, 1'b0, 1'b0, sv);
         nchk++;
         if ({d0_valid, d0_data, d0_ferr, d0_ovr} !== {1'b1, d, ~sv, 1'b0})
            $display("FAIL rnd8n1_%0d got=%b/%h/%b%b exp=1/%h/%b0",
                     n, d0_valid, d0_data, d0_ferr, d0_ovr, d, ~sv);
         else npass++;
         read0();
      end
      do_reset();
      for (int n = 0; n < 6; n++) begin
         d = 8'($urandom);
         pb = 1'($urandom_range(0, 1));
         ep = 1'b0;
         for (int i = 0; i < 8; i++) ep = ep ^ d[i];
         send_frame(d, 1'b1, pb, 1'b1);
         nchk++;
         if ({d1_valid, d1_data, d1_perr, d1_ferr} !== {1'b1, d, pb != ep, 1'b0})
            $display("FAIL rnd8e1_%0d got=%b/%h/%b%b exp=1/%h/%b0",
                     n, d1_valid, d1_data, d1_perr, d1_ferr, d, pb != ep);
         else npass++;
         read1();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_parity();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
